// File: rtl/axi_slv_wr_arbiter.sv
`default_nettype none
// ============================================================================
// axi_slv_wr_arbiter : round-robin AW arbiter with in-order W steering  (rev 1.0)
// ============================================================================
module axi_slv_wr_arbiter #(
  parameter int MST_NUM      = 3,
  parameter int SLV_OSTD_NUM = 4,
  parameter int AWCH_W       = 53,
  parameter int WCH_W        = 47
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [MST_NUM-1:0]                mst_awvalid,
  output logic [MST_NUM-1:0]                mst_awready,
  input  logic [MST_NUM*AWCH_W-1:0]         mst_awch,
  output logic                              slv_awvalid,
  input  logic                              slv_awready,
  output logic [AWCH_W-1:0]                 slv_awch,
  input  logic [MST_NUM-1:0]                mst_wvalid,
  output logic [MST_NUM-1:0]                mst_wready,
  input  logic [MST_NUM-1:0]                mst_wlast,
  input  logic [MST_NUM*WCH_W-1:0]          mst_wch,
  output logic                              slv_wvalid,
  input  logic                              slv_wready,
  output logic                              slv_wlast,
  output logic [WCH_W-1:0]                  slv_wch,
  output logic [$clog2(MST_NUM)-1:0]        aw_grant,
  output logic                              aw_busy,
  output logic [$clog2(SLV_OSTD_NUM):0]     ostd_cnt
);

  localparam int MW = $clog2(MST_NUM);
  localparam int PW = $clog2(SLV_OSTD_NUM);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   last_grant, rr_pick, grant_nxt;
  logic            rr_found;
  logic            not_full, empty, push, pop;
  logic [MW-1:0]   order_q [SLV_OSTD_NUM];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [MW-1:0]   head;

  // First requester searching upward from last_grant+1, wrapping at MST_NUM.
  always_comb begin : rr_search
    int          idx;
    logic [MW-1:0] idx_m;
    rr_pick  = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_m    = '0;
    for (int k = 1; k <= MST_NUM; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= MST_NUM) idx = idx - MST_NUM;
      idx_m = MW'(idx);
      if (!rr_found && mst_awvalid[idx_m]) begin
        rr_pick  = idx_m;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = aw_grant;
    case (state)
      IDLE: if (rr_found && not_full) begin
        state_nxt = BUSY;
        grant_nxt = rr_pick;
      end
      BUSY: if (push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      aw_grant   <= '0;
      last_grant <= MW'(MST_NUM - 1);
    end else begin
      state    <= state_nxt;
      aw_grant <= grant_nxt;
      if (push) last_grant <= aw_grant;
    end
  end

  assign aw_busy     = (state == BUSY);
  assign slv_awvalid = aw_busy & mst_awvalid[aw_grant];
  assign slv_awch    = mst_awch[aw_grant*AWCH_W +: AWCH_W];
  assign push        = slv_awvalid & slv_awready;

  assign not_full   = (ostd_cnt != CW'(SLV_OSTD_NUM));
  assign empty      = (ostd_cnt == '0);
  assign head       = order_q[rd_ptr];
  // An empty FIFO masks everything so W issued ahead of its AW simply stalls.
  assign slv_wvalid = !empty & mst_wvalid[head];
  assign slv_wlast  = !empty & mst_wlast[head];
  assign slv_wch    = mst_wch[head*WCH_W +: WCH_W];
  assign pop        = slv_wvalid & slv_wready & slv_wlast;

  for (genvar i = 0; i < MST_NUM; i++) begin : g_rdy
    assign mst_awready[i] = aw_busy & (aw_grant == MW'(i)) & slv_awready;
    assign mst_wready[i]  = !empty & (head == MW'(i)) & slv_wready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ostd_cnt <= '0;
      for (int j = 0; j < SLV_OSTD_NUM; j++) order_q[j] <= '0;
    end else begin
      if (push) begin
        order_q[wr_ptr] <= aw_grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   ostd_cnt <= ostd_cnt + 1'b1;
        2'b01:   ostd_cnt <= ostd_cnt - 1'b1;
        default: ostd_cnt <= ostd_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
